hiscore_upload: RTL
===================

HISCORE_UPLOAD -- requirements
Module: hiscore_upload

Interface
REQ-001 Parameter ADDR_W, default 6, meaning EAROM shadow RAM address width.
REQ-002 Parameter SIZE, default 64, meaning the number of valid bytes served; SIZE SHALL be at most 2**ADDR_W.
REQ-003 Parameter QUIET_CYCLES, default 25_000_000, meaning the idle cycles after the last EAROM write before an autosave request (1 s at 25 MHz).
REQ-004 clk_25  in  1  sole clock; all logic SHALL be rising-edge on clk_25.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ioctl_upload  in  1  high for the whole HPS upload session.
REQ-007 ioctl_rd  in  1  single-cycle read strobe from HPS.
REQ-008 ioctl_addr  in  25  byte address of the current read.
REQ-009 ioctl_din  out  8  data returned to HPS.
REQ-010 ioctl_upload_req  out  1  single-cycle pulse requesting that HPS start an upload (autosave).
REQ-011 ram_addr  out  ADDR_W  shadow RAM read address.
REQ-012 ram_rd  out  1  shadow RAM read enable.
REQ-013 ram_q  in  8  shadow RAM data, valid 1 cycle after ram_rd.
REQ-014 earom_wr  in  1  game write strobe to the EAROM; marks contents dirty.
REQ-015 busy  out  1  high while a fetch is in flight.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, CAPTURE and HOLD.
REQ-017 IDLE->FETCH on ioctl_rd && ioctl_upload && ioctl_addr<SIZE: ram_addr<=ioctl_addr[ADDR_W-1:0], ram_rd=1 for exactly that cycle.
REQ-018 FETCH->CAPTURE unconditionally, after the 1-cycle RAM latency.
REQ-019 CAPTURE: ioctl_din<=ram_q, then ->HOLD.
REQ-020 ioctl_din SHALL be valid no later than 3 cycles after ioctl_rd and SHALL hold until the next accepted read.
REQ-021 HOLD->IDLE on the next cycle; busy=1 in FETCH, CAPTURE and HOLD only.
REQ-022 ioctl_rd with ioctl_addr>=SIZE: ioctl_din<=8'hFF on the next cycle, no RAM access, FSM stays IDLE.
REQ-023 ioctl_rd while busy SHALL be ignored; the HPS guarantees read spacing of at least 4 cycles.
REQ-024 ioctl_rd with ioctl_upload=0 SHALL be ignored.
REQ-025 ioctl_upload falling mid-fetch: the FSM SHALL return to IDLE on the next cycle, ram_rd=0, and ioctl_din SHALL keep its last value.
REQ-026 Address compare SHALL use the full 25 bits; there is no wrap-around of high addresses onto the RAM.

Reset
REQ-027 On reset assertion, without waiting for a clock edge: state=IDLE, ioctl_din=8'h00, ram_addr=0, ram_rd=0, busy=0, ioctl_upload_req=0, dirty=0, quiet counter=0.
REQ-028 Reset asserted mid-fetch SHALL abort the fetch; the first read after release SHALL be served normally.

Configuration
REQ-029 Macro HISCORE_AUTOSAVE_EN, when defined, enables the autosave behaviour in REQ-030 to REQ-033.
REQ-030 earom_wr SHALL set dirty and clear the quiet counter.
REQ-031 When dirty && !ioctl_upload, the counter SHALL increment; on reaching QUIET_CYCLES-1 it SHALL pulse ioctl_upload_req for 1 cycle, clear dirty and clear the counter.
REQ-032 While ioctl_upload=1 the counter SHALL hold, and no request SHALL be issued.
REQ-033 earom_wr in the same cycle as the request pulse: the pulse SHALL still occur, and dirty SHALL end set.
REQ-034 Without HISCORE_AUTOSAVE_EN: ioctl_upload_req SHALL be tied 0, earom_wr is unused, and no counter or dirty logic SHALL be present.

Structure
REQ-035 Package hiscore_pkg SHALL hold the state enum (IDLE/FETCH/CAPTURE/HOLD), the OOR_BYTE=8'hFF constant and a clog2-based counter width function.
REQ-036 Sub-module hiscore_autosave_timer SHALL hold the dirty flag, the quiet counter and the request pulse, and SHALL only be instantiated under HISCORE_AUTOSAVE_EN.

Verification
REQ-037 RAM[5]=8'hA7, upload=1, rd at addr 5 -> ram_rd pulse at addr 5, ioctl_din=8'hA7 within 3 cycles, busy high for 3 cycles.
REQ-038 rd at addr 64 and at addr 25'h10005 -> ioctl_din=8'hFF, ram_rd never asserted.
REQ-039 Sequential rds at addr 0..63, spaced 4 cycles -> all 64 bytes match the RAM image; a second rd 1 cycle after the first is ignored.
REQ-040 Fetch aborted by reset at FETCH, then rd at addr 2 (RAM=8'h3C) -> all outputs 0 during reset; then ioctl_din=8'h3C.
REQ-041 AUTOSAVE_EN, QUIET_CYCLES=100, earom_wr at t0 -> single ioctl_upload_req at t0+100; a further earom_wr at t0+50 moves the pulse to t0+150.
REQ-042 AUTOSAVE_EN, earom_wr then ioctl_upload=1 for 500 cycles -> no pulse during upload; pulse follows the remaining count after upload falls.

Source files
------------

// File: rtl/hiscore_pkg.sv
// Shared types and constants for the hiscore upload block.
package hiscore_pkg;

  // Width of the HPS ioctl byte address bus
  localparam int unsigned IOCTL_ADDR_W = 25;

  // Byte returned for reads beyond the served image
  localparam logic [7:0] OOR_BYTE = 8'hFF;

  // Read-sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Bits needed for a counter running 0 .. n-1 (never narrower than 1)
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hiscore_autosave_timer.sv
// Autosave timer: tracks unsaved EAROM writes and raises a one-cycle upload
// request once the game has been quiet for QUIET_CYCLES cycles.
// The quiet count freezes while an HPS upload is in progress.
module hiscore_autosave_timer
  import hiscore_pkg::*;
#(
  parameter int unsigned QUIET_CYCLES = 25_000_000
) (
  input  logic clk_25,
  input  logic reset,
  input  logic earom_wr,
  input  logic ioctl_upload,
  output logic upload_req
);

  localparam int unsigned CNT_W = cnt_width(QUIET_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(QUIET_CYCLES - 1);

  logic             dirty;
  logic [CNT_W-1:0] cnt;
  logic             fire_c;

  // Quiet period elapsed on this edge
  assign fire_c = dirty && !ioctl_upload && (cnt == LAST);

  // Dirty flag, quiet counter and request pulse; a write coinciding with
  // the pulse re-arms dirty so that write is saved on a later request.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      dirty      <= 1'b0;
      cnt        <= '0;
      upload_req <= 1'b0;
    end else begin
      upload_req <= fire_c;
      if (fire_c) begin
        dirty <= earom_wr;
        cnt   <= '0;
      end else if (earom_wr) begin
        dirty <= 1'b1;
        cnt   <= '0;
      end else if (dirty && !ioctl_upload) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/hiscore_upload.sv
// Hiscore upload: serves EAROM shadow RAM bytes to the HPS during an ioctl
// upload session. Each accepted read costs one RAM cycle plus a capture
// cycle; the byte is presented on ioctl_din and held until the next
// accepted read. Reads past SIZE return OOR_BYTE without touching the RAM.
// Optional feature: define HISCORE_AUTOSAVE_EN to request an upload after
// QUIET_CYCLES idle cycles following the last EAROM write.
module hiscore_upload
  import hiscore_pkg::*;
#(
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned SIZE         = 64,
  parameter int unsigned QUIET_CYCLES = 25_000_000
) (
  input  logic                    clk_25,
  input  logic                    reset,
  input  logic                    ioctl_upload,
  input  logic                    ioctl_rd,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  output logic [7:0]              ioctl_din,
  output logic                    ioctl_upload_req,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic                    ram_rd,
  input  logic [7:0]              ram_q,
  input  logic                    earom_wr,
  output logic                    busy
);

  localparam logic [IOCTL_ADDR_W-1:0] SIZE_ADDR = IOCTL_ADDR_W'(SIZE);

  state_t state;
  logic   in_range_c;
  logic   accept_c;

  // Full-width compare so high addresses never alias onto the RAM
  assign in_range_c = (ioctl_addr < SIZE_ADDR);

  // Read request seen while idle inside an upload session
  assign accept_c = ioctl_rd && ioctl_upload;

  // Read sequencer with registered RAM strobe, data and busy flag.
  // Dropping ioctl_upload mid-fetch aborts back to IDLE and leaves
  // ioctl_din untouched.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ioctl_din <= 8'h00;
      ram_addr  <= '0;
      ram_rd    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ram_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            if (in_range_c) begin
              state    <= FETCH;
              ram_addr <= ioctl_addr[ADDR_W-1:0];
              ram_rd   <= 1'b1;
              busy     <= 1'b1;
            end else begin
              ioctl_din <= OOR_BYTE;
            end
          end
        end
        FETCH: begin
          if (!ioctl_upload) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (!ioctl_upload) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            ioctl_din <= ram_q;
            state     <= HOLD;
          end
        end
        HOLD: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef HISCORE_AUTOSAVE_EN
  hiscore_autosave_timer #(
    .QUIET_CYCLES(QUIET_CYCLES)
  ) u_autosave_timer (
    .clk_25      (clk_25),
    .reset       (reset),
    .earom_wr    (earom_wr),
    .ioctl_upload(ioctl_upload),
    .upload_req  (ioctl_upload_req)
  );
`else
  // Autosave compiled out: no request, write strobe and quiet period unused
  localparam int unsigned unused_quiet_cycles = QUIET_CYCLES;
  logic unused_earom_wr;
  assign unused_earom_wr  = earom_wr;
  assign ioctl_upload_req = 1'b0;
`endif

endmodule
